if_fetch_ctrl: RTL
==================

# if_fetch_ctrl

Fetch sequencer for the instruction-memory block RAM in the IF stage of the pipelined CPU. It owns the fetch PC and drives the IM's chip-enable and word address. It accounts for the RAM's one-cycle read latency and presents a registered PC/instruction/valid triple to the IF/ID boundary. It also honours back-pressure (stall) from the hazard unit and redirects from branch/jump resolution, and it traps fetches outside the IM window.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000: first fetch address after reset. Also the base byte address of the IM window (word index 0xC00).
- IM_DEPTH, 2048: number of 32-bit words in the IM window.

Ports:
- clk  in  1: single clock; all state updates on its rising edge.
- rst  in  1: synchronous, active-high reset.
- stall  in  1: downstream did not accept the current if_* outputs this cycle.
- redirect_valid  in  1: branch/jump/exception redirect this cycle.
- redirect_pc  in  32: redirect target byte address.
- im_ce  out  1: IM enable (combinational).
- im_addr  out  14: IM word address, [15:2] of the issued PC (combinational).
- im_rdata  in  32: IM read data, valid one cycle after an im_ce=1 cycle.
- if_pc  out  32: PC of the instruction presented.
- if_instr  out  32: instruction presented.
- if_valid  out  1: if_pc/if_instr are a live instruction.
- pc_fault  out  1: fetch PC misaligned or outside the IM window (sticky).

## Operation
- Registers:
  - fetch_pc (next address to issue)
  - out_pc
  - out_valid
  - hold_reg/hold_valid (skid copy of im_rdata)
  - state
- States:
  - RUN:
    - Normal fetch.
    - Issue when ~stall & ~redirect_valid & pc_ok: im_ce=1, im_addr=fetch_pc[15:2], fetch_pc<=fetch_pc+4, out_pc<=fetch_pc, out_valid<=1.
  - RUN with stall=1 and no redirect:
    - im_ce=0; fetch_pc, out_pc and out_valid hold.
    - On the first stall cycle, hold_reg<=im_rdata and hold_valid<=1.
    - hold_valid clears on the first non-stalled cycle.
  - FAULT:
    - Entered when a RUN issue attempt finds !pc_ok.
    - pc_fault<=1, out_valid<=0, im_ce=0.
    - Stays in FAULT until redirect or reset.
- pc_ok: fetch_pc[1:0]==0 and (fetch_pc[31:2]-RESET_PC[31:2]) < IM_DEPTH.
  - Unsigned 30-bit subtraction, so addresses below the base wrap large and fail.
- if_instr = hold_valid ? hold_reg : im_rdata.
- if_pc = out_pc; if_valid = out_valid.
- Redirect (any state, priority over stall and fault):
  - fetch_pc<=redirect_pc, out_valid<=0, hold_valid<=0, pc_fault<=0, state<=RUN.
  - im_ce=0 in the redirect cycle.
  - The in-flight word is squashed.
- fetch_pc+4 wraps modulo 2^32. Wrapping out of the window is caught by pc_ok on the next issue attempt.

## Timing
- Reset values:
  - fetch_pc=RESET_PC, out_pc=RESET_PC
  - out_valid=0, hold_valid=0, hold_reg=0
  - pc_fault=0, state=RUN
  - im_ce forced 0 while rst=1.
- First cycle after rst deasserts: im_ce=1, im_addr=RESET_PC[15:2].
- Next cycle: if_valid=1, if_pc=RESET_PC.
- Fetch latency: the address issued in cycle N appears on if_* in cycle N+1. Throughput is 1 instruction/cycle without stall.
- Stall asserted in cycle N: if_* in N+1 are identical to those in N, for any stall length.
- Redirect in cycle N:
  - if_valid=0 in N+1; target issued in N+1; if_valid=1 with if_pc=target in N+2.
  - Penalty: 1 bubble.
- Redirect and stall in the same cycle: redirect wins.
- Reset mid-operation (including mid-stall or in FAULT): all registers return to reset values next cycle. Pending redirect is ignored.
- pc_fault asserts the cycle after the failing issue attempt. if_valid is 0 that same cycle.

## Test plan
- Reset release, no stall, IM preloaded word i = 0x1000_0000+i:
  - cycles 1..4 show if_pc 0x3000, 0x3004, 0x3008, 0x300C with matching if_instr.
  - if_valid=0 in the first post-reset cycle only.
- Stall for 3 cycles while if_pc=0x3008:
  - if_pc/if_instr hold 0x3008 / 0x1000_0002; im_ce=0 throughout.
  - After release the stream resumes at 0x300C with no duplicates and no gaps.
- Redirect to 0x3100 while if_pc=0x3004, concurrent with stall:
  - next cycle if_valid=0; the following cycle if_pc=0x3100, if_instr=0x1000_0040.
- Fetch past the window (redirect to 0x3000+4*2047):
  - one valid instruction, then pc_fault=1, if_valid=0, im_ce=0.
  - A later redirect to 0x3000 clears pc_fault and restarts fetch.
- Misaligned redirect 0x3002 and below-window redirect 0x2FFC: each yields pc_fault=1, with no im_ce pulse.
- rst asserted during a stall:
  - next cycle if_valid=0, pc_fault=0.
  - First fetch after release is 0x3000.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch sequencer for the instruction-memory block RAM
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_ce,
    output logic [13:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        pc_fault
);

    localparam logic [29:0] BASE_WORD  = RESET_PC[31:2];
    localparam logic [29:0] DEPTH_WORD = 30'(IM_DEPTH);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_out_pc;
    logic        r_out_valid;
    logic [31:0] r_hold_reg;
    logic        r_hold_valid;
    logic        r_pc_fault;

    logic [29:0] w_word_off;
    logic        w_pc_ok;
    logic        w_issue;
    logic        w_fault_trip;

    // Word offset from the window base; addresses below the base wrap to a
    // large unsigned value and so fail the depth check as well.
    assign w_word_off = r_fetch_pc[31:2] - BASE_WORD;
    assign w_pc_ok    = (r_fetch_pc[1:0] == 2'b00) && (w_word_off < DEPTH_WORD);

    // State register: reset and redirect both land in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: redirect always recovers; a blocked issue attempt traps.
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = S_RUN;
        end else if ((r_state == S_RUN) && !stall && !w_pc_ok) begin
            w_state_next = S_FAULT;
        end
    end

    // Output decode: an issue attempt happens only in RUN with no stall and
    // no redirect; it either fetches or trips the fault.
    always_comb begin
        w_issue      = 1'b0;
        w_fault_trip = 1'b0;
        if (!rst && !redirect_valid && (r_state == S_RUN) && !stall) begin
            if (w_pc_ok) begin
                w_issue = 1'b1;
            end else begin
                w_fault_trip = 1'b1;
            end
        end
    end

    // Fetch datapath: PC advance, presented PC/valid, fault flag and the skid
    // copy that keeps if_instr stable once the RAM output moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_out_pc     <= RESET_PC;
            r_out_valid  <= 1'b0;
            r_hold_reg   <= 32'h0000_0000;
            r_hold_valid <= 1'b0;
            r_pc_fault   <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc   <= redirect_pc;
            r_out_valid  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_pc_fault   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_fetch_pc  <= r_fetch_pc + 32'd4;
                r_out_pc    <= r_fetch_pc;
                r_out_valid <= 1'b1;
            end else if (w_fault_trip) begin
                r_pc_fault  <= 1'b1;
                r_out_valid <= 1'b0;
            end else if (r_state == S_FAULT) begin
                r_out_valid <= 1'b0;
            end

            if (stall) begin
                if (!r_hold_valid) begin
                    r_hold_reg   <= im_rdata;
                    r_hold_valid <= 1'b1;
                end
            end else begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    assign im_ce    = w_issue;
    assign im_addr  = r_fetch_pc[15:2];
    assign if_pc    = r_out_pc;
    assign if_instr = r_hold_valid ? r_hold_reg : im_rdata;
    assign if_valid = r_out_valid;
    assign pc_fault = r_pc_fault;

endmodule
